// File: rtl/dec_pkg.sv
// Shared constants and state type for the 3-to-8 decode-and-hold block family.
package dec_pkg;

    localparam int unsigned IDX_W = 3;
    localparam int unsigned OUT_W = 8;

    typedef enum logic {
        DEC_IDLE,
        DEC_HOLD
    } dec_state_t;

endpackage

// File: rtl/dec3x8_pulse_if.sv
// Index handshake plus strobe/status bundle between an 8x3 encoder and dec3x8_pulse.
interface dec3x8_pulse_if
    import dec_pkg::*;
();

    logic [IDX_W-1:0] in_idx;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] out;
    logic             busy;
    logic             done;

    modport master (
        output in_idx,
        output in_valid,
        input  in_ready,
        input  out,
        input  busy,
        input  done
    );

    modport slave (
        input  in_idx,
        input  in_valid,
        output in_ready,
        output out,
        output busy,
        output done
    );

endinterface

// File: rtl/dec3x8.sv
// Purely combinational one-hot decoder: onehot = 1 << idx.
module dec3x8
    import dec_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [OUT_W-1:0] onehot
);

    always_comb begin
        onehot = OUT_W'(1) << idx;
    end

endmodule

// File: rtl/dec3x8_pulse.sv
// Accepts an encoded index and holds the matching one-hot strobe for HOLD cycles, then pulses done.
// Define DEC3X8_RETRIGGER_EN to accept a new index in the last hold cycle (gap-free strobes).
module dec3x8_pulse
    import dec_pkg::*;
#(
    parameter int unsigned HOLD  = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    dec3x8_pulse_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD - 1);

    dec_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [OUT_W-1:0] dec_out;
    logic             last;
    logic             accept;

    dec3x8 u_dec (
        .idx    (bus.in_idx),
        .onehot (dec_out)
    );

    assign last = (cnt == '0);

    always_comb begin
        bus.in_ready = 1'b0;
        if (rst_n) begin
            if (state == DEC_IDLE) begin
                bus.in_ready = 1'b1;
            end
`ifdef DEC3X8_RETRIGGER_EN
            else if (last) begin
                bus.in_ready = 1'b1;
            end
`endif
        end
    end

    // dec_out is only captured on accept, so an X index with in_valid low never reaches a register.
    assign accept = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= DEC_IDLE;
            cnt      <= '0;
            bus.out  <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                DEC_IDLE: begin
                    if (accept) begin
                        state    <= DEC_HOLD;
                        bus.out  <= dec_out;
                        bus.busy <= 1'b1;
                        cnt      <= CNT_LOAD;
                    end
                end
                DEC_HOLD: begin
                    if (!last) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        bus.done <= 1'b1;
                        // accept can only be high here when retriggering is built in.
                        if (accept) begin
                            bus.out <= dec_out;
                            cnt     <= CNT_LOAD;
                        end else begin
                            state    <= DEC_IDLE;
                            bus.out  <= '0;
                            bus.busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= DEC_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec3x8_pulse.sv
// Bench for dec3x8_pulse: three instances (HOLD=4,1,2) checked each cycle against a
// remaining-cycles reference model, with directed scenarios followed by random traffic.
module tb_dec3x8_pulse;
    import dec_pkg::*;

    localparam int N = 3;
    localparam int HOLDS [N] = '{4, 1, 2};
`ifdef DEC3X8_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [2:0] idx_drv   [N];
    logic       valid_drv [N];
    logic       rdy_obs   [N];
    logic [7:0] out_obs   [N];
    logic       busy_obs  [N];
    logic       done_obs  [N];

    int checks = 0;
    int errors = 0;

    // Reference model: cycles of strobe left, index being strobed, done flag.
    int rem [N];
    int cur [N];
    bit dn  [N];

    always #5 clk = ~clk;

    dec3x8_pulse_if bus0 ();
    dec3x8_pulse_if bus1 ();
    dec3x8_pulse_if bus2 ();

    dec3x8_pulse #(.HOLD(4), .CNT_W(8)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    dec3x8_pulse #(.HOLD(1), .CNT_W(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    dec3x8_pulse #(.HOLD(2), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    assign bus0.in_idx   = idx_drv[0];
    assign bus0.in_valid = valid_drv[0];
    assign bus1.in_idx   = idx_drv[1];
    assign bus1.in_valid = valid_drv[1];
    assign bus2.in_idx   = idx_drv[2];
    assign bus2.in_valid = valid_drv[2];

    assign rdy_obs[0]  = bus0.in_ready;
    assign out_obs[0]  = bus0.out;
    assign busy_obs[0] = bus0.busy;
    assign done_obs[0] = bus0.done;
    assign rdy_obs[1]  = bus1.in_ready;
    assign out_obs[1]  = bus1.out;
    assign busy_obs[1] = bus1.busy;
    assign done_obs[1] = bus1.done;
    assign rdy_obs[2]  = bus2.in_ready;
    assign out_obs[2]  = bus2.out;
    assign busy_obs[2] = bus2.busy;
    assign done_obs[2] = bus2.done;

    task automatic chk(input string tag, input int d, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s dut%0d observed %h expected %h", tag, d, got, exp);
        end
    endtask

    // One clock: check in_ready before the edge, advance the model, check registered outputs after.
    task automatic cycle();
        bit         acc [N];
        logic [2:0] ai  [N];
        bit         er;
        logic [7:0] eo;
        #1;
        for (int d = 0; d < N; d++) begin
            er = (rst_n === 1'b1) && (rem[d] == 0 || (RETRIG && rem[d] == 1));
            chk("in_ready", d, {7'b0, rdy_obs[d]}, {7'b0, er});
            acc[d] = er && (valid_drv[d] === 1'b1);
            ai[d]  = idx_drv[d];
        end
        @(posedge clk);
        for (int d = 0; d < N; d++) begin
            if (rst_n !== 1'b1) begin
                rem[d] = 0;
                dn[d]  = 1'b0;
            end else begin
                dn[d] = (rem[d] == 1);
                if (acc[d]) begin
                    rem[d] = HOLDS[d];
                    cur[d] = int'(ai[d]);
                end else if (rem[d] > 0) begin
                    rem[d]--;
                end
            end
        end
        @(negedge clk);
        for (int d = 0; d < N; d++) begin
            eo = (rem[d] > 0) ? (8'd1 << cur[d]) : 8'h00;
            chk("out", d, out_obs[d], eo);
            chk("busy", d, {7'b0, busy_obs[d]}, {7'b0, rem[d] > 0});
            chk("done", d, {7'b0, done_obs[d]}, {7'b0, dn[d]});
        end
    endtask

    task automatic idle_all();
        for (int d = 0; d < N; d++) begin
            valid_drv[d] = 1'b0;
            idx_drv[d]   = 3'd0;
        end
    endtask

    initial begin
        for (int d = 0; d < N; d++) begin
            rem[d] = 0;
            cur[d] = 0;
            dn[d]  = 1'b0;
        end

        // Reset held 3 cycles with a valid request pending.
        rst_n = 1'b0;
        for (int d = 0; d < N; d++) begin
            valid_drv[d] = 1'b1;
            idx_drv[d]   = 3'd5;
        end
        repeat (3) cycle();
        rst_n = 1'b1;
        idle_all();
        cycle();

        // Single accept of index 6 on the HOLD=4 instance.
        valid_drv[0] = 1'b1;
        idx_drv[0]   = 3'd6;
        cycle();
        valid_drv[0] = 1'b0;
        repeat (6) cycle();

        // Sweep all indices on the HOLD=1 instance, request held until taken.
        for (int i = 0; i < 8; i++) begin
            valid_drv[1] = 1'b1;
            idx_drv[1]   = 3'(i);
            cycle();
            cycle();
        end
        idle_all();
        repeat (2) cycle();

        // Valid held through a hold while the index changes 3 -> 7.
        valid_drv[0] = 1'b1;
        idx_drv[0]   = 3'd3;
        cycle();
        idx_drv[0] = 3'd7;
        repeat (5) cycle();
        valid_drv[0] = 1'b0;
        repeat (6) cycle();

        // Reset in the second hold cycle of index 2: no done may follow.
        valid_drv[0] = 1'b1;
        idx_drv[0]   = 3'd2;
        cycle();
        valid_drv[0] = 1'b0;
        cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        repeat (6) cycle();

        // Index 1 then index 4 offered in the last hold cycle of the HOLD=2 instance.
        valid_drv[2] = 1'b1;
        idx_drv[2]   = 3'd1;
        cycle();
        valid_drv[2] = 1'b0;
        cycle();
        valid_drv[2] = 1'b1;
        idx_drv[2]   = 3'd4;
        cycle();
        valid_drv[2] = 1'b0;
        repeat (4) cycle();

        // Random traffic, X indices while invalid, occasional resets.
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            for (int d = 0; d < N; d++) begin
                valid_drv[d] = ($urandom_range(0, 2) != 0);
                if (!valid_drv[d] && $urandom_range(0, 3) == 0) begin
                    idx_drv[d] = 3'bxxx;
                end else begin
                    idx_drv[d] = 3'($urandom_range(0, 7));
                end
            end
            cycle();
        end
        rst_n = 1'b1;
        idle_all();
        repeat (6) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
